// File: rtl/decodificador_display.sv
`timescale 1ns/1ps
// Four-digit multiplexed 7-segment driver (common anode, active-low) for the MM:SS timer.
// Shadow-latched BCD digits, leading-zero blanking, colon dot and whole-display blink.
module decodificador_display #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 125
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] digitos,
    input  logic        carregar,
    input  logic        enablen,
    input  logic        apagar_zeros,
    input  logic        pisca,
    input  logic        dois_pontos,
    output logic [6:0]  segmentos,
    output logic [3:0]  anodos,
    output logic        ponto
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [15:0]   shadow;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [BW-1:0] bcnt;
    logic          fase;

    logic       tick, frame_end, blank_cur;
    logic [3:0] cur;
    logic [6:0] seg_nxt;
    logic [3:0] an_nxt;
    logic       pt_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick      = (presc == PW'(SCAN_DIV - 1));
    assign frame_end = tick && (idx == 2'd3);
    assign cur       = shadow[{idx, 2'b00} +: 4];
    // Tens-of-minutes blanks on its own zero; units-of-minutes only when both minute digits are zero.
    assign blank_cur = apagar_zeros &&
                       (((idx == 2'd3) && (shadow[15:12] == 4'd0)) ||
                        ((idx == 2'd2) && (shadow[15:8] == 8'd0)));

    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = 7'b1111111;
        pt_nxt  = 1'b1;
        if (!(enablen || fase || blank_cur)) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = decode(cur);
            pt_nxt  = !((idx == 2'd2) && dois_pontos);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shadow    <= '0;
            presc     <= '0;
            idx       <= '0;
            bcnt      <= '0;
            fase      <= 1'b0;
            segmentos <= 7'b1111111;
            anodos    <= 4'b1111;
            ponto     <= 1'b1;
        end else begin
            if (carregar) shadow <= digitos;
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) idx <= idx + 2'd1;
            // Blink phase is frozen at the lit phase whenever blinking is off.
            if (!pisca) begin
                bcnt <= '0;
                fase <= 1'b0;
            end else if (frame_end) begin
                if (bcnt == BW'(BLINK_DIV - 1)) begin
                    bcnt <= '0;
                    fase <= ~fase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
            segmentos <= seg_nxt;
            anodos    <= an_nxt;
            ponto     <= pt_nxt;
        end
    end
endmodule

// File: tb/tb_decodificador_display.sv
`timescale 1ns/1ps
// Bench for decodificador_display: cycle-level behavioural model plus directed literal checks
// and a randomized phase.
module tb_decodificador_display;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic        clock = 0, resetn = 0;
    logic [15:0] digitos = '0;
    logic        carregar = 0, enablen = 0, apagar_zeros = 0, pisca = 0, dois_pontos = 0;
    logic [6:0]  segmentos;
    logic [3:0]  anodos;
    logic        ponto;

    int checks = 0, errors = 0;

    decodificador_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clock(clock), .resetn(resetn), .digitos(digitos), .carregar(carregar),
        .enablen(enablen), .apagar_zeros(apagar_zeros), .pisca(pisca),
        .dois_pontos(dois_pontos), .segmentos(segmentos), .anodos(anodos), .ponto(ponto));

    always #5 clock = ~clock;

    logic [6:0] tbl [16];
    initial begin
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100; tbl[3] = 7'b0110000;
        tbl[4] = 7'b0011001; tbl[5] = 7'b0010010; tbl[6] = 7'b0000010; tbl[7] = 7'b1111000;
        tbl[8] = 7'b0000000; tbl[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) tbl[i] = 7'b0111111;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: time since reset decides the slot, frames since pisca rose decide the phase.
    int         m_cyc, m_frames;
    logic [15:0] m_sh;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_pt;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_cyc = 0; m_frames = 0; m_sh = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_pt = 1'b1;
        end else begin
            int slot, val, fz;
            bit blank;
            slot  = (m_cyc / SCAN_DIV) % 4;
            val   = (m_sh >> (slot * 4)) & 15;
            fz    = (m_frames / BLINK_DIV) % 2;
            blank = apagar_zeros && ((slot == 3 && m_sh[15:12] == 0) ||
                                     (slot == 2 && m_sh[15:8] == 0));
            if (enablen || fz == 1 || blank) begin
                e_an = 4'hF; e_seg = 7'h7F; e_pt = 1'b1;
            end else begin
                e_an  = 4'hF;
                e_an[slot] = 1'b0;
                e_seg = tbl[val];
                e_pt  = !(slot == 2 && dois_pontos);
            end
            m_cyc++;
            if (carregar) m_sh = digitos;
            if (!pisca) m_frames = 0;
            else if (m_cyc % (4 * SCAN_DIV) == 0) m_frames++;
        end
    end

    always @(negedge clock) begin
        chk("model_anodos", {28'd0, anodos}, {28'd0, e_an});
        chk("model_segmentos", {25'd0, segmentos}, {25'd0, e_seg});
        chk("model_ponto", {31'd0, ponto}, {31'd0, e_pt});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic load(input logic [15:0] v);
        digitos = v; carregar = 1;
        cyc(1);
        carregar = 0;
        cyc(1);
    endtask

    task automatic wait_an(input logic [3:0] t, input string nm);
        int n = 0;
        while (anodos !== t && n < 64) begin cyc(1); n++; end
        chk(nm, {28'd0, anodos}, {28'd0, t});
    endtask

    initial begin
        int dark_a, dark_b, cnt, bad, mask;
        // 1. reset and load/scan
        cyc(3);
        chk("reset_anodos", {28'd0, anodos}, 32'hF);
        chk("reset_segmentos", {25'd0, segmentos}, 32'h7F);
        chk("reset_ponto", {31'd0, ponto}, 32'd1);
        resetn = 1;
        cyc(1);
        chk("first_edge_anodos", {28'd0, anodos}, 32'hE);
        chk("first_edge_seg", {25'd0, segmentos}, {25'd0, 7'b1000000});
        load(16'h1234);
        wait_an(4'b1110, "scan_slot0"); chk("scan_seg0", {25'd0, segmentos}, {25'd0, 7'b0011001});
        wait_an(4'b1101, "scan_slot1"); chk("scan_seg1", {25'd0, segmentos}, {25'd0, 7'b0110000});
        wait_an(4'b1011, "scan_slot2"); chk("scan_seg2", {25'd0, segmentos}, {25'd0, 7'b0100100});
        wait_an(4'b0111, "scan_slot3"); chk("scan_seg3", {25'd0, segmentos}, {25'd0, 7'b1111001});

        // 2. decode sweep
        for (int v = 0; v < 16; v++) begin
            load({12'h000, 4'(v)});
            wait_an(4'b1110, "sweep_slot0");
            chk($sformatf("sweep_seg_%0d", v), {25'd0, segmentos}, {25'd0, tbl[v]});
        end

        // 3. leading-zero blanking
        apagar_zeros = 1;
        foreach (digitos[i]) ;
        for (int k = 0; k < 2; k++) begin
            load(k == 0 ? 16'h0005 : 16'h0105);
            mask = 0; bad = 0;
            for (int i = 0; i < 16; i++) begin
                cyc(1);
                for (int b = 0; b < 4; b++) if (anodos[b] == 1'b0) mask |= (1 << b);
                if (k == 0 && anodos == 4'b1101 && segmentos != 7'b1000000) bad++;
            end
            chk(k == 0 ? "blank_mask_0005" : "blank_mask_0105", mask, k == 0 ? 32'h3 : 32'h7);
            if (k == 0) chk("blank_digit1_zero", bad, 0);
        end

        // 4. colon
        apagar_zeros = 0; dois_pontos = 1;
        load(16'h1230);
        cnt = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (ponto == 1'b0) begin cnt++; if (anodos != 4'b1011) bad++; end
        end
        chk("colon_count", cnt, 4);
        chk("colon_slot", bad, 0);
        apagar_zeros = 1;
        load(16'h0030);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin cyc(1); if (ponto == 1'b0) cnt++; end
        chk("colon_blanked", cnt, 0);
        apagar_zeros = 0; dois_pontos = 0;

        // 5. blink
        resetn = 0; pisca = 1;
        cyc(2);
        resetn = 1;
        dark_a = 0; dark_b = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (anodos == 4'hF) begin if (i < 32) dark_a++; else dark_b++; end
        end
        chk("blink_lit_half", dark_a, 0);
        chk("blink_dark_half", dark_b, 32);
        cyc(40);
        chk("blink_mid_dark", {28'd0, anodos}, 32'hF);
        pisca = 0;
        cyc(2);
        chk("blink_resume", {31'd0, anodos != 4'hF}, 32'd1);

        // 6. enable and async reset
        enablen = 1; cnt = 0;
        for (int i = 0; i < 12; i++) begin cyc(1); if (anodos == 4'hF) cnt++; end
        chk("enable_dark", cnt, 12);
        enablen = 0;
        cyc(8);
        wait_an(4'b1011, "pre_reset_slot2");
        #2 resetn = 0;
        #1;
        chk("async_anodos", {28'd0, anodos}, 32'hF);
        chk("async_segmentos", {25'd0, segmentos}, 32'h7F);
        chk("async_ponto", {31'd0, ponto}, 32'd1);
        cyc(1);
        resetn = 1;
        cyc(1);
        chk("post_reset_anodos", {28'd0, anodos}, 32'hE);

        // randomized phase against the model
        for (int i = 0; i < 1500; i++) begin
            cyc(1);
            digitos  = 16'($urandom);
            carregar = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) enablen = ~enablen;
            if ($urandom_range(0, 15) == 0) apagar_zeros = ~apagar_zeros;
            if ($urandom_range(0, 15) == 0) dois_pontos = ~dois_pontos;
            if ($urandom_range(0, 199) == 0) pisca = ~pisca;
        end
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
